character_bank: RTL and testbench

- Holds combat stats for NUM_CHARS characters in one block: class, health, special, poison counter.
- Applies signed health/special deltas through a valid/ready command port, with saturation and rejection rules.
- On each turn boundary, runs an end-of-turn sweep over all characters: poison damage and special regeneration.
- Sits between the battle controller (commands, turn_end) and the display/AI logic (combinational read port, alive_mask).

---
 rtl/character_bank.sv | 249 ++++++++++++++++++++++++
 tb/tb_character_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/character_bank.sv
// Combat stat bank: per-slot class/health/special/poison, with a command port and an end-of-turn sweep.
// Latency: command response 1 cycle after accept; sweep takes NUM_CHARS cycles; the read port is combinational.
// Backpressure: cmd_ready drops while sweeping and in any cycle with init_valid or turn_end present.
module character_bank #(
  parameter int NUM_CHARS  = 4,
  parameter int IDX_W      = 2,
  parameter int HP_W       = 9,
  parameter int SP_W       = 5,
  parameter int DELTA_W    = 8,
  parameter int POISON_W   = 3,
  parameter int POISON_DMG = 5,
  parameter int SP_REGEN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_valid,
  input  logic [IDX_W-1:0]     init_idx,
  input  logic [1:0]           init_class,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IDX_W-1:0]     cmd_idx,
  input  logic [DELTA_W-1:0]   cmd_hp_delta,
  input  logic [DELTA_W-1:0]   cmd_sp_delta,
  input  logic [POISON_W-1:0]  cmd_poison,
  output logic                 rsp_valid,
  output logic                 rsp_ok,
  output logic                 rsp_defeated,
  input  logic                 turn_end,
  output logic                 sweep_done,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [HP_W-1:0]      rd_health,
  output logic [SP_W-1:0]      rd_special,
  output logic [2:0]           rd_speed,
  output logic [3:0]           rd_dodge,
  output logic [POISON_W-1:0]  rd_poison,
  output logic [NUM_CHARS-1:0] alive_mask
);

  // Sum widths: two guard bits above the wider operand so signed sums never wrap.
  localparam int HS_W = ((HP_W > DELTA_W) ? HP_W : DELTA_W) + 2;
  localparam int SS_W = ((SP_W > DELTA_W) ? SP_W : DELTA_W) + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  function automatic logic [HP_W-1:0] max_hp(input logic [1:0] c);
    case (c)
      2'd0:    return HP_W'(175);
      2'd1:    return HP_W'(150);
      2'd2:    return HP_W'(200);
      default: return HP_W'(150);
    endcase
  endfunction

  function automatic logic [SP_W-1:0] max_sp(input logic [1:0] c);
    case (c)
      2'd0:    return SP_W'(8);
      2'd1:    return SP_W'(10);
      2'd2:    return SP_W'(10);
      default: return SP_W'(8);
    endcase
  endfunction

  function automatic logic [2:0] cls_speed(input logic [1:0] c);
    case (c)
      2'd0:    return 3'd4;
      2'd1:    return 3'd6;
      2'd2:    return 3'd2;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [3:0] cls_dodge(input logic [1:0] c);
    case (c)
      2'd0:    return 4'd5;
      2'd1:    return 4'd7;
      2'd2:    return 4'd5;
      default: return 4'd9;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     sweep_idx_q;
  logic                 sweep_last;

  logic [1:0]           cls_q    [NUM_CHARS];
  logic [HP_W-1:0]      hp_q     [NUM_CHARS];
  logic [SP_W-1:0]      sp_q     [NUM_CHARS];
  logic [POISON_W-1:0]  poison_q [NUM_CHARS];

  logic                 init_idx_ok, cmd_idx_ok, rd_idx_ok;
  logic                 cmd_accept, cmd_ok, cmd_defeated;
  logic [1:0]           cur_cls;
  logic [HP_W-1:0]      cur_hp, hp_new;
  logic [SP_W-1:0]      cur_sp, sp_new;
  logic signed [HS_W-1:0] hp_sum;
  logic signed [SS_W-1:0] sp_sum;

  logic [1:0]           sw_cls;
  logic [HP_W-1:0]      sw_hp, sw_hp_new;
  logic [SP_W-1:0]      sw_sp, sw_sp_new;
  logic [SP_W:0]        sw_sp_sum;
  logic [POISON_W-1:0]  sw_poison, sw_poison_new;
  logic                 sw_alive, sw_poisoned;

  assign init_idx_ok = ({1'b0, init_idx} < (IDX_W+1)'(NUM_CHARS));
  assign cmd_idx_ok  = ({1'b0, cmd_idx}  < (IDX_W+1)'(NUM_CHARS));
  assign rd_idx_ok   = ({1'b0, rd_idx}   < (IDX_W+1)'(NUM_CHARS));

  assign cmd_ready  = (state_q == IDLE) && !turn_end && !init_valid;
  assign cmd_accept = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: init blocks a same-cycle turn_end; the sweep ends after the last slot.
  always_comb begin
    state_d    = state_q;
    sweep_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (!init_valid && turn_end) state_d = SWEEP;
      end
      SWEEP: begin
        if (sweep_idx_q == LAST_IDX) begin
          sweep_last = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep index: restarts at slot 0 on each sweep, steps one slot per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  sweep_idx_q <= '0;
    else if (state_q == IDLE)                 sweep_idx_q <= '0;
    else if (sweep_last)                      sweep_idx_q <= '0;
    else                                      sweep_idx_q <= sweep_idx_q + 1'b1;
  end

  // Command evaluation against the current target slot, with saturation and reject rules.
  always_comb begin
    cur_cls = cmd_idx_ok ? cls_q[cmd_idx] : 2'd0;
    cur_hp  = cmd_idx_ok ? hp_q[cmd_idx]  : '0;
    cur_sp  = cmd_idx_ok ? sp_q[cmd_idx]  : '0;
    hp_sum  = $signed({{(HS_W-HP_W){1'b0}}, cur_hp})
            + $signed({{(HS_W-DELTA_W){cmd_hp_delta[DELTA_W-1]}}, cmd_hp_delta});
    sp_sum  = $signed({{(SS_W-SP_W){1'b0}}, cur_sp})
            + $signed({{(SS_W-DELTA_W){cmd_sp_delta[DELTA_W-1]}}, cmd_sp_delta});
    if (hp_sum[HS_W-1])
      hp_new = '0;
    else if (hp_sum > $signed({{(HS_W-HP_W){1'b0}}, max_hp(cur_cls)}))
      hp_new = max_hp(cur_cls);
    else
      hp_new = hp_sum[HP_W-1:0];
    if (sp_sum[SS_W-1])
      sp_new = '0;
    else if (sp_sum > $signed({{(SS_W-SP_W){1'b0}}, max_sp(cur_cls)}))
      sp_new = max_sp(cur_cls);
    else
      sp_new = sp_sum[SP_W-1:0];
    // A special cost the slot cannot afford rejects the whole command.
    cmd_ok       = cmd_idx_ok && (cur_hp != '0) && !sp_sum[SS_W-1];
    cmd_defeated = cmd_ok && (hp_new == '0);
  end

  // End-of-turn update for the slot under the sweep index; dead slots pass through unchanged.
  always_comb begin
    sw_cls      = cls_q[sweep_idx_q];
    sw_hp       = hp_q[sweep_idx_q];
    sw_sp       = sp_q[sweep_idx_q];
    sw_poison   = poison_q[sweep_idx_q];
    sw_alive    = (sw_hp != '0);
    sw_poisoned = sw_alive && (sw_poison != '0);
    sw_hp_new     = sw_hp;
    sw_poison_new = sw_poison;
    if (sw_poisoned) begin
      sw_hp_new     = (sw_hp > HP_W'(POISON_DMG)) ? sw_hp - HP_W'(POISON_DMG) : '0;
      sw_poison_new = sw_poison - 1'b1;
    end
    // Regen is keyed on health before the poison tick, so a slot killed this tick still regenerates.
    sw_sp_sum = {1'b0, sw_sp} + (SP_W+1)'(SP_REGEN);
    sw_sp_new = sw_sp;
    if (sw_alive)
      sw_sp_new = (sw_sp_sum > {1'b0, max_sp(sw_cls)}) ? max_sp(sw_cls) : sw_sp_sum[SP_W-1:0];
  end

  // Slot storage: init has priority, then the sweep, then accepted commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        cls_q[k]    <= 2'd0;
        hp_q[k]     <= HP_W'(175);
        sp_q[k]     <= SP_W'(8);
        poison_q[k] <= '0;
      end
    end else if (state_q == IDLE && init_valid) begin
      if (init_idx_ok) begin
        cls_q[init_idx]    <= init_class;
        hp_q[init_idx]     <= max_hp(init_class);
        sp_q[init_idx]     <= max_sp(init_class);
        poison_q[init_idx] <= '0;
      end
    end else if (state_q == SWEEP) begin
      hp_q[sweep_idx_q]     <= sw_hp_new;
      sp_q[sweep_idx_q]     <= sw_sp_new;
      poison_q[sweep_idx_q] <= sw_poison_new;
    end else if (cmd_accept && cmd_ok) begin
      hp_q[cmd_idx] <= hp_new;
      sp_q[cmd_idx] <= sp_new;
      if (cmd_poison != '0) poison_q[cmd_idx] <= cmd_poison;
    end
  end

  // Response and sweep-completion pulses, one cycle after the triggering edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_ok       <= 1'b0;
      rsp_defeated <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      rsp_valid    <= cmd_accept;
      rsp_ok       <= cmd_accept && cmd_ok;
      rsp_defeated <= cmd_accept && cmd_defeated;
      sweep_done   <= sweep_last;
    end
  end

  // Combinational read port; out-of-range selects read as zero.
  always_comb begin
    rd_health  = rd_idx_ok ? hp_q[rd_idx]              : '0;
    rd_special = rd_idx_ok ? sp_q[rd_idx]              : '0;
    rd_speed   = rd_idx_ok ? cls_speed(cls_q[rd_idx])  : '0;
    rd_dodge   = rd_idx_ok ? cls_dodge(cls_q[rd_idx])  : '0;
    rd_poison  = rd_idx_ok ? poison_q[rd_idx]          : '0;
  end

  // Alive flags for the display/AI side.
  always_comb begin
    alive_mask = '0;
    for (int k = 0; k < NUM_CHARS; k++) alive_mask[k] = (hp_q[k] != '0);
  end

endmodule

// File: tb/tb_character_bank.sv
// Directed bench for character_bank: reset, init, commands, saturation, rejects, sweeps, reset mid-sweep.
// Each step drives inputs just after a rising edge and samples outputs 1 time unit later.
// Expected values are hand-computed from the class table and the saturation/poison rules.
module tb_character_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_valid;
  logic [1:0] init_idx;
  logic [1:0] init_class;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_idx;
  logic [7:0] cmd_hp_delta;
  logic [7:0] cmd_sp_delta;
  logic [2:0] cmd_poison;
  logic       rsp_valid;
  logic       rsp_ok;
  logic       rsp_defeated;
  logic       turn_end;
  logic       sweep_done;
  logic [1:0] rd_idx;
  logic [8:0] rd_health;
  logic [4:0] rd_special;
  logic [2:0] rd_speed;
  logic [3:0] rd_dodge;
  logic [2:0] rd_poison;
  logic [3:0] alive_mask;

  int n_cmp = 0;
  int n_err = 0;

  character_bank dut (
    .clk(clk), .rst(rst),
    .init_valid(init_valid), .init_idx(init_idx), .init_class(init_class),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx),
    .cmd_hp_delta(cmd_hp_delta), .cmd_sp_delta(cmd_sp_delta), .cmd_poison(cmd_poison),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_defeated(rsp_defeated),
    .turn_end(turn_end), .sweep_done(sweep_done),
    .rd_idx(rd_idx), .rd_health(rd_health), .rd_special(rd_special),
    .rd_speed(rd_speed), .rd_dodge(rd_dodge), .rd_poison(rd_poison),
    .alive_mask(alive_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] idx, input int hp, input int sp);
    rd_idx = idx;
    #1;
    chk({tag, "_hp"}, 32'(rd_health), 32'(hp));
    chk({tag, "_sp"}, 32'(rd_special), 32'(sp));
  endtask

  // Issue one command; on return the response cycle is visible.
  task automatic send(input logic [1:0] idx, input logic [7:0] hp, input logic [7:0] sp,
                      input logic [2:0] po);
    cmd_valid = 1'b1; cmd_idx = idx; cmd_hp_delta = hp; cmd_sp_delta = sp; cmd_poison = po;
    #1;
    chk("send_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0; cmd_hp_delta = '0; cmd_sp_delta = '0; cmd_poison = '0;
    chk("send_rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  // One full sweep: cmd_ready low for 4 cycles, sweep_done on the 4th edge after turn_end.
  task automatic run_sweep();
    int low;
    low = 0;
    turn_end = 1'b1;
    #1;
    chk("turn_end_ready", 32'(cmd_ready), 32'd0);
    step();
    turn_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!cmd_ready) low++;
      chk("sweep_done_early", 32'(sweep_done), 32'd0);
      step();
    end
    chk("sweep_done_pulse", 32'(sweep_done), 32'd1);
    chk("sweep_ready_low_cycles", 32'(low), 32'd4);
    chk("sweep_ready_back", 32'(cmd_ready), 32'd1);
    step();
    chk("sweep_done_clear", 32'(sweep_done), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; init_valid = 0; init_idx = 0; init_class = 0;
    cmd_valid = 0; cmd_idx = 0; cmd_hp_delta = 0; cmd_sp_delta = 0; cmd_poison = 0;
    turn_end = 0; rd_idx = 0;
    step(); step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_ok", 32'(rsp_ok), 32'd0);
    chk("rst_rsp_defeated", 32'(rsp_defeated), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    rst = 1'b0;
    step();
    // Reset state of slot 0.
    rd_chk("rst_slot0", 2'd0, 175, 8);
    chk("rst_speed", 32'(rd_speed), 32'd4);
    chk("rst_dodge", 32'(rd_dodge), 32'd5);
    chk("rst_poison", 32'(rd_poison), 32'd0);
    chk("rst_alive", 32'(alive_mask), 32'hF);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // Init slot 1 as class 2.
    init_valid = 1'b1; init_idx = 2'd1; init_class = 2'd2;
    #1;
    chk("init_blocks_ready", 32'(cmd_ready), 32'd0);
    step();
    init_valid = 1'b0;
    rd_chk("init_slot1", 2'd1, 200, 10);
    chk("init_speed", 32'(rd_speed), 32'd2);
    chk("init_dodge", 32'(rd_dodge), 32'd5);

    // Two hits of -128: 200 -> 72 -> 0 (clamped), second also spends 3 special.
    send(2'd1, 8'h80, 8'h00, 3'd0);
    chk("hit1_ok", 32'(rsp_ok), 32'd1);
    chk("hit1_defeated", 32'(rsp_defeated), 32'd0);
    rd_chk("hit1_slot1", 2'd1, 72, 10);
    send(2'd1, 8'h80, 8'hFD, 3'd0);
    chk("hit2_ok", 32'(rsp_ok), 32'd1);
    chk("hit2_defeated", 32'(rsp_defeated), 32'd1);
    rd_chk("hit2_slot1", 2'd1, 0, 7);
    chk("hit2_alive", 32'(alive_mask), 32'hD);
    // Heal on a dead slot is rejected.
    send(2'd1, 8'd50, 8'h00, 3'd0);
    chk("heal_dead_ok", 32'(rsp_ok), 32'd0);
    chk("heal_dead_defeated", 32'(rsp_defeated), 32'd0);
    rd_chk("heal_dead_slot1", 2'd1, 0, 7);

    // Unaffordable special cost rejects the whole command.
    send(2'd0, 8'hF6, 8'hF7, 3'd0);
    chk("sp_reject_ok", 32'(rsp_ok), 32'd0);
    rd_chk("sp_reject_slot0", 2'd0, 175, 8);
    // Heal saturates at class max.
    send(2'd0, 8'd40, 8'h00, 3'd0);
    chk("heal_clamp_ok", 32'(rsp_ok), 32'd1);
    rd_chk("heal_clamp_slot0", 2'd0, 175, 8);

    // Poison slot 2, drain some special on slot 3 so regen is visible.
    send(2'd2, 8'hFC, 8'h00, 3'd2);
    chk("poison_ok", 32'(rsp_ok), 32'd1);
    rd_chk("poison_slot2", 2'd2, 171, 8);
    chk("poison_cnt", 32'(rd_poison), 32'd2);
    send(2'd3, 8'h00, 8'hFD, 3'd0);
    rd_chk("drain_slot3", 2'd3, 175, 5);

    run_sweep();
    rd_chk("sw1_slot2", 2'd2, 166, 8);
    chk("sw1_poison", 32'(rd_poison), 32'd1);
    rd_chk("sw1_slot3", 2'd3, 175, 6);
    rd_chk("sw1_slot1_dead", 2'd1, 0, 7);
    run_sweep();
    rd_chk("sw2_slot2", 2'd2, 161, 8);
    chk("sw2_poison", 32'(rd_poison), 32'd0);
    rd_chk("sw2_slot3", 2'd3, 175, 7);
    run_sweep();
    rd_chk("sw3_slot2", 2'd2, 161, 8);
    rd_chk("sw3_slot3", 2'd3, 175, 8);

    // turn_end beats a same-cycle command; then reset lands mid-sweep.
    cmd_valid = 1'b1; cmd_idx = 2'd0; cmd_hp_delta = 8'hF6; turn_end = 1'b1;
    #1;
    chk("tie_ready", 32'(cmd_ready), 32'd0);
    step();
    cmd_valid = 1'b0; cmd_hp_delta = '0; turn_end = 1'b0;
    chk("tie_no_rsp", 32'(rsp_valid), 32'd0);
    rd_chk("tie_slot0", 2'd0, 175, 8);
    step();
    rst = 1'b1;
    #1;
    rd_chk("midrst_slot1", 2'd1, 175, 8);
    chk("midrst_speed1", 32'(rd_speed), 32'd4);
    rd_chk("midrst_slot2", 2'd2, 175, 8);
    chk("midrst_poison2", 32'(rd_poison), 32'd0);
    chk("midrst_alive", 32'(alive_mask), 32'hF);
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (sweep_done) done_seen++;
      step();
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    chk("midrst_idle_ready", 32'(cmd_ready), 32'd1);

    // Three back-to-back commands, one response per cycle.
    cmd_valid = 1'b1; cmd_idx = 2'd0; cmd_sp_delta = '0; cmd_poison = '0;
    cmd_hp_delta = 8'hFF;
    #1;
    chk("b2b_ready0", 32'(cmd_ready), 32'd1);
    step();
    chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
    chk("b2b_ok1", 32'(rsp_ok), 32'd1);
    cmd_hp_delta = 8'hFE;
    step();
    chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
    chk("b2b_ok2", 32'(rsp_ok), 32'd1);
    cmd_hp_delta = 8'hFD;
    step();
    chk("b2b_rsp3", 32'(rsp_valid), 32'd1);
    chk("b2b_ok3", 32'(rsp_ok), 32'd1);
    cmd_valid = 1'b0; cmd_hp_delta = '0;
    step();
    chk("b2b_rsp_end", 32'(rsp_valid), 32'd0);
    rd_chk("b2b_slot0", 2'd0, 169, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
